// File: rtl/rng_request_arbiter.sv
// Shares one external LFSR between two requesters: seeds it after reset, advances it
// DRAW_STEPS times per draw and returns the result with a one-cycle acknowledge.
module rng_request_arbiter #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      DRAW_STEPS = 4,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(4'b1110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lfsr_state,
  output logic             lfsr_step,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  input  logic             req_0,
  input  logic             req_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic [WIDTH-1:0] rnd_out,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {INIT, IDLE, STEP, DELIVER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             grant_q, grant_d;
  logic             ack_0_d, ack_1_d;
  logic [WIDTH-1:0] rnd_d;
  logic             step_c, load_c;
  logic             elig_0, elig_1;

  // A requester seeing its ack this cycle is not yet eligible for another draw.
  assign elig_0 = req_0 & ~ack_0;
  assign elig_1 = req_1 & ~ack_1;

  assign lfsr_step = step_c;
  assign lfsr_load = load_c;
  assign lfsr_seed = SEED;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_0_d = 1'b0;
    ack_1_d = 1'b0;
    rnd_d   = rnd_out;
    step_c  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      INIT: begin
        load_c  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (elig_0 && (!elig_1 || !ptr_q)) begin
          grant_d = 1'b0;
          ptr_d   = 1'b1;
          cnt_d   = '0;
          state_d = STEP;
        end else if (elig_1) begin
          grant_d = 1'b1;
          ptr_d   = 1'b0;
          cnt_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        // An all-zero LFSR never leaves zero, so reseed and retry without counting.
        if (lfsr_state == '0) begin
          load_c = 1'b1;
        end else begin
          step_c = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DRAW_STEPS - 1)) state_d = DELIVER;
        end
      end
      DELIVER: begin
        rnd_d   = lfsr_state;
        ack_0_d = ~grant_q;
        ack_1_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      step_c = 1'b0;
      load_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      ack_0   <= 1'b0;
      ack_1   <= 1'b0;
      rnd_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_0   <= ack_0_d;
      ack_1   <= ack_1_d;
      rnd_out <= rnd_d;
    end
  end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench for rng_request_arbiter with a behavioural 4-bit LFSR
// (shift left, new bit0 = b2^b3, load beats step).
module tb_rng_request_arbiter;

  localparam logic [3:0] SEED = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lfsr_state;
  logic       lfsr_step, lfsr_load;
  logic [3:0] lfsr_seed;
  logic       req_0, req_1;
  logic       ack_0, ack_1;
  logic [3:0] rnd_out;
  logic       busy;

  logic [3:0] lfsr_q = 4'b0000;
  logic       force_zero = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  rng_request_arbiter dut (
    .clk(clk), .rst(rst), .lfsr_state(lfsr_state), .lfsr_step(lfsr_step),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .req_0(req_0), .req_1(req_1),
    .ack_0(ack_0), .ack_1(ack_1), .rnd_out(rnd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lfsr_load)      lfsr_q <= SEED;
    else if (lfsr_step) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign lfsr_state = force_zero ? 4'b0000 : lfsr_q;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits at most budget cycles for an ack; acks = {ack_1, ack_0}, 0 on timeout.
  task automatic wait_ack(input int budget, output logic [1:0] acks, output int n);
    n = 0;
    acks = 2'b00;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (ack_0 || ack_1) begin
        acks = {ack_1, ack_0};
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    #1;
    check("rst_step", 8'(lfsr_step), 8'd0);
    check("rst_load", 8'(lfsr_load), 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_load", 8'(lfsr_load), 8'd1);
    check("init_busy", 8'(busy), 8'd1);
    @(negedge clk);
    check("post_init_load", 8'(lfsr_load), 8'd0);
    check("post_init_lfsr", 8'(lfsr_state), 8'(SEED));
    check("post_init_busy", 8'(busy), 8'd0);
    check("post_init_acks", 8'({ack_1, ack_0}), 8'd0);
    check("post_init_rnd", 8'(rnd_out), 8'd0);
  endtask

  logic [2:0] sd_exp [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b000};
  logic [3:0] sim_val [4] = '{4'b0010, 4'b0110, 4'b1011, 4'b1100};
  logic [3:0] held_val [3] = '{4'b0010, 4'b0110, 4'b1011};

  initial begin
    logic [1:0] acks;
    int n;
    rst = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;

    do_reset();

    // Single draw for requester 0; {step, ack_0, ack_1} per cycle.
    req_0 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("single_c%0d", c), 8'({lfsr_step, ack_0, ack_1}), 8'(sd_exp[c-1]));
      if (c == 6) begin
        check("single_rnd", 8'(rnd_out), 8'b0010);
        req_0 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("single_no_redraw", 8'(busy), 8'd0);

    // Both held: grants alternate 0,1,0,1 every DRAW_STEPS+2 cycles.
    do_reset();
    req_0 = 1'b1;
    req_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, acks, n);
      check($sformatf("both_id%0d", k), 8'(acks), (k % 2 == 0) ? 8'b01 : 8'b10);
      check($sformatf("both_rnd%0d", k), 8'(rnd_out), 8'(sim_val[k]));
      check($sformatf("both_gap%0d", k), 8'(n), 8'd6);
    end
    req_0 = 1'b0;
    req_1 = 1'b0;

    // Requester 1 held alone: acks never adjacent, spacing at least the minimum period.
    do_reset();
    req_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(20, acks, n);
      check($sformatf("held_id%0d", k), 8'(acks), 8'b10);
      check($sformatf("held_rnd%0d", k), 8'(rnd_out), 8'(held_val[k]));
      check($sformatf("held_gap%0d", k), 8'(n >= 6), 8'd1);
    end
    req_1 = 1'b0;
    @(negedge clk);
    check("held_ack_drop", 8'(ack_1), 8'd0);

    // Zero lockup on the first STEP cycle: reload, then four steps from SEED.
    req_0 = 1'b1;
    @(negedge clk);
    force_zero = 1'b1;
    #1;
    check("lock_load", 8'(lfsr_load), 8'd1);
    check("lock_step", 8'(lfsr_step), 8'd0);
    @(negedge clk);
    force_zero = 1'b0;
    #1;
    check("lock_resume_step", 8'(lfsr_step), 8'd1);
    wait_ack(20, acks, n);
    check("lock_id", 8'(acks), 8'b01);
    check("lock_rnd", 8'(rnd_out), 8'b0010);
    check("lock_late", 8'(n), 8'd5);
    req_0 = 1'b0;
    @(negedge clk);

    // Reset in cycle 3 of a draw: no ack, reseed, then a fresh request is served.
    req_0 = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_step", 8'(lfsr_step), 8'd1);
    rst = 1'b1;
    req_0 = 1'b0;
    #1;
    check("mid_rst_outs", 8'({lfsr_step, lfsr_load}), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_no_ack", 8'({ack_1, ack_0}), 8'd0);
    #1;
    check("mid_reload", 8'(lfsr_load), 8'd1);
    @(negedge clk);
    check("mid_lfsr", 8'(lfsr_state), 8'(SEED));
    req_1 = 1'b1;
    wait_ack(20, acks, n);
    check("mid_id", 8'(acks), 8'b10);
    check("mid_rnd", 8'(rnd_out), 8'b0010);
    check("mid_lat", 8'(n), 8'd6);
    req_1 = 1'b0;
    @(negedge clk);

    // Pointer left at 1 by a grant to 0 must return to 0 after reset.
    req_0 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_0 = 1'b1;
    req_1 = 1'b1;
    wait_ack(20, acks, n);
    check("ptr_reset_id", 8'(acks), 8'b01);
    check("ptr_reset_rnd", 8'(rnd_out), 8'b0010);
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
